// File: rtl/traffic_defs.sv
// Shared light, direction and phase encodings for the intersection controllers.
package traffic_defs;

  localparam int unsigned NUM_DIR = 4;
  localparam int unsigned LT_W    = 3;

  localparam logic [LT_W-1:0] LT_RED = 3'b100;
  localparam logic [LT_W-1:0] LT_YEL = 3'b010;
  localparam logic [LT_W-1:0] LT_GRN = 3'b001;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_e;

  function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [1:0] dir);
    return NUM_DIR'(1) << dir;
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_rr_pick.sv
// Circular priority finder: first set request bit at or after the pointer.
module rr_pick
  import traffic_defs::*;
(
  input  logic [NUM_DIR-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               valid_c_o,
  output logic [1:0]         idx_c_o
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    valid_c_o = 1'b0;
    idx_c_o   = ptr_i;
    cand      = ptr_i;
    for (int k = NUM_DIR - 1; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        valid_c_o = 1'b1;
        idx_c_o   = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Request-driven round-robin signal scheduler for a four-way intersection.
// Optional emergency preemption enabled with `define EMERG_PREEMPT_EN.
module traffic_phase_arbiter
  import traffic_defs::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 12,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned CNT_W     = 5
) (
  input  logic               clk,
  input  logic               rst_a,
  input  logic [NUM_DIR-1:0] req,
`ifdef EMERG_PREEMPT_EN
  input  logic               emerg_req,
  input  logic [1:0]         emerg_dir,
`endif
  output logic [LT_W-1:0]    n_lights,
  output logic [LT_W-1:0]    s_lights,
  output logic [LT_W-1:0]    e_lights,
  output logic [LT_W-1:0]    w_lights,
  output logic [NUM_DIR-1:0] grant,
  output logic [1:0]         phase
);

  phase_e                           state_q, state_d;
  logic [1:0]                       owner_q, owner_d;
  logic [1:0]                       rr_q, rr_d;
  logic [CNT_W-1:0]                 timer_q, timer_d, timer_inc;
  logic [NUM_DIR-1:0]               grant_q, grant_d;
  logic [NUM_DIR-1:0][LT_W-1:0]     lights_q, lights_d;
  logic [NUM_DIR-1:0]               others;
  logic [1:0]                       pick_ptr, pick_idx;
  logic                             pick_valid;
  logic                             emg_act;
  logic [1:0]                       emg_dir;

`ifdef EMERG_PREEMPT_EN
  assign emg_act = emerg_req;
  assign emg_dir = emerg_dir;
`else
  assign emg_act = 1'b0;
  assign emg_dir = DIR_N;
`endif

  // At clearance exit the search starts just past the previous owner.
  assign pick_ptr  = (state_q == PH_ALLRED) ? owner_q + 2'd1 : rr_q;
  assign others    = req & ~dir_onehot(owner_q);
  assign timer_inc = (timer_q >= CNT_W'(GREEN_MAX)) ? timer_q : timer_q + CNT_W'(1);

  rr_pick u_rr_pick (
    .req_i     (req),
    .ptr_i     (pick_ptr),
    .valid_c_o (pick_valid),
    .idx_c_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    timer_d  = timer_inc;
    grant_d  = '0;
    lights_d = {NUM_DIR{LT_RED}};

    case (state_q)
      PH_IDLE: begin
        timer_d = '0;
        if (emg_act) begin
          state_d = PH_GREEN;
          owner_d = emg_dir;
        end else if (pick_valid) begin
          state_d = PH_GREEN;
          owner_d = pick_idx;
        end
      end
      PH_GREEN: begin
        if (emg_act) begin
          if (owner_q != emg_dir) begin
            state_d = PH_YELLOW;
            timer_d = '0;
          end
        end else if ((others != '0) &&
                     ((timer_q >= CNT_W'(GREEN_MAX - 1)) ||
                      ((timer_q >= CNT_W'(GREEN_MIN - 1)) && !req[owner_q]))) begin
          state_d = PH_YELLOW;
          timer_d = '0;
        end
      end
      PH_YELLOW: begin
        if (timer_q >= CNT_W'(YELLOW_T - 1)) begin
          state_d = PH_ALLRED;
          timer_d = '0;
        end
      end
      PH_ALLRED: begin
        if (timer_q >= CNT_W'(ALLRED_T - 1)) begin
          rr_d    = owner_q + 2'd1;
          timer_d = '0;
          if (emg_act) begin
            state_d = PH_GREEN;
            owner_d = emg_dir;
          end else if (pick_valid) begin
            state_d = PH_GREEN;
            owner_d = pick_idx;
          end else begin
            state_d = PH_IDLE;
          end
        end
      end
      default: state_d = PH_IDLE;
    endcase

    // Moore outputs derived from the state being entered.
    if (state_d == PH_GREEN) begin
      lights_d[owner_d] = LT_GRN;
      grant_d           = dir_onehot(owner_d);
    end else if (state_d == PH_YELLOW) begin
      lights_d[owner_d] = LT_YEL;
      grant_d           = dir_onehot(owner_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q  <= PH_IDLE;
      owner_q  <= DIR_N;
      rr_q     <= DIR_N;
      timer_q  <= '0;
      grant_q  <= '0;
      lights_q <= {NUM_DIR{LT_RED}};
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      lights_q <= lights_d;
    end
  end

  assign n_lights = lights_q[DIR_N];
  assign s_lights = lights_q[DIR_S];
  assign e_lights = lights_q[DIR_E];
  assign w_lights = lights_q[DIR_W];
  assign grant    = grant_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Scoreboard bench for traffic_phase_arbiter; covers EMERG_PREEMPT_EN when defined.
module tb_traffic_phase_arbiter;
  import traffic_defs::*;

  localparam int unsigned GMIN = 4;
  localparam int unsigned GMAX = 12;
  localparam int unsigned YT   = 3;
  localparam int unsigned ART  = 1;

  typedef struct packed {
    logic [3:0][2:0] lights;
    logic [3:0]      grant;
    logic [1:0]      phase;
  } exp_t;

  logic       clk;
  logic       rst_a;
  logic [3:0] req;
  logic       emerg_req;
  logic [1:0] emerg_dir;
  logic [2:0] n_lights, s_lights, e_lights, w_lights;
  logic [3:0] grant;
  logic [1:0] phase;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   lit;

  traffic_phase_arbiter dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .req       (req),
`ifdef EMERG_PREEMPT_EN
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
`endif
    .n_lights  (n_lights),
    .s_lights  (s_lights),
    .e_lights  (e_lights),
    .w_lights  (w_lights),
    .grant     (grant),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Expected bus state for a phase owned by a given approach.
  function automatic exp_t model(input logic [1:0] ph, input logic [1:0] own);
    exp_t e;
    e.lights = {4{LT_RED}};
    e.grant  = '0;
    e.phase  = ph;
    if (ph == PH_GREEN) begin
      e.lights[own] = LT_GRN;
      e.grant       = 4'b0001 << own;
    end else if (ph == PH_YELLOW) begin
      e.lights[own] = LT_YEL;
      e.grant       = 4'b0001 << own;
    end
    return e;
  endfunction

  task automatic step(input logic [3:0] r, input logic rst, input logic [1:0] ph,
                      input logic [1:0] own, input int n);
    repeat (n) begin
      @(negedge clk);
      req   = r;
      rst_a = rst;
      exp_q.push_back(model(ph, own));
    end
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1, PH_IDLE, DIR_N, 2);
  endtask

  // Compare every produced output against the oldest expectation.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check_eq("n_lights", 32'(n_lights), 32'(mon_e.lights[DIR_N]));
      check_eq("s_lights", 32'(s_lights), 32'(mon_e.lights[DIR_S]));
      check_eq("e_lights", 32'(e_lights), 32'(mon_e.lights[DIR_E]));
      check_eq("w_lights", 32'(w_lights), 32'(mon_e.lights[DIR_W]));
      check_eq("grant", 32'(grant), 32'(mon_e.grant));
      check_eq("phase", 32'(phase), 32'(mon_e.phase));
      lit = int'(n_lights != LT_RED) + int'(s_lights != LT_RED) +
            int'(e_lights != LT_RED) + int'(w_lights != LT_RED);
      check_eq("one_lit", 32'(lit <= 1), 32'd1);
      check_eq("grant_1hot", 32'($onehot0(grant)), 32'd1);
    end
  end

  initial begin
    clk       = 1'b0;
    rst_a     = 1'b1;
    req       = 4'b0000;
    emerg_req = 1'b0;
    emerg_dir = DIR_N;
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;

    // Reset and idle with no requests.
    do_reset();
    step(4'b0000, 1'b0, PH_IDLE, DIR_N, 50);

    // Sole N requester rests in green.
    step(4'b0001, 1'b0, PH_GREEN, DIR_N, 100);

    // N held, E waiting: green runs to the maximum.
    do_reset();
    step(4'b0001, 1'b0, PH_GREEN, DIR_N, 2);
    step(4'b0101, 1'b0, PH_GREEN, DIR_N, GMAX - 2);
    step(4'b0101, 1'b0, PH_YELLOW, DIR_N, YT);
    step(4'b0101, 1'b0, PH_ALLRED, DIR_N, ART);
    step(4'b0100, 1'b0, PH_GREEN, DIR_E, 5);

    // N drops, S waiting: green ends at the minimum.
    do_reset();
    step(4'b0001, 1'b0, PH_GREEN, DIR_N, 1);
    step(4'b0010, 1'b0, PH_GREEN, DIR_N, GMIN - 1);
    step(4'b0010, 1'b0, PH_YELLOW, DIR_N, YT);
    step(4'b0010, 1'b0, PH_ALLRED, DIR_N, ART);
    step(4'b0010, 1'b0, PH_GREEN, DIR_S, 3);

    // All approaches requesting: full round-robin rotation.
    do_reset();
    for (int d = 0; d < 4; d++) begin
      step(4'b1111, 1'b0, PH_GREEN, 2'(d), GMAX);
      step(4'b1111, 1'b0, PH_YELLOW, 2'(d), YT);
      step(4'b1111, 1'b0, PH_ALLRED, 2'(d), ART);
    end
    step(4'b1111, 1'b0, PH_GREEN, DIR_N, GMAX);

    // Reset asserted in the middle of yellow.
    do_reset();
    step(4'b0001, 1'b0, PH_GREEN, DIR_N, 1);
    step(4'b0010, 1'b0, PH_GREEN, DIR_N, GMIN - 1);
    step(4'b0010, 1'b0, PH_YELLOW, DIR_N, 1);
    step(4'b0010, 1'b1, PH_IDLE, DIR_N, 1);
    step(4'b0000, 1'b0, PH_IDLE, DIR_N, 3);

`ifdef EMERG_PREEMPT_EN
    // Emergency for W cuts N green short, then W holds past the maximum.
    do_reset();
    step(4'b0001, 1'b0, PH_GREEN, DIR_N, 2);
    @(negedge clk);
    emerg_req = 1'b1;
    emerg_dir = DIR_W;
    req       = 4'b0001;
    exp_q.push_back(model(PH_YELLOW, DIR_N));
    step(4'b0001, 1'b0, PH_YELLOW, DIR_N, YT - 1);
    step(4'b0001, 1'b0, PH_ALLRED, DIR_N, ART);
    step(4'b0001, 1'b0, PH_GREEN, DIR_W, GMAX + 4);
    emerg_req = 1'b0;
`endif

    @(posedge clk);
    #2;
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
